// File: rtl/rc4_phase_sequencer.sv
// -----------------------------------------------------------------------------
// rc4_phase_sequencer
//
// Top-level controller for the RC4 key-search datapath. For every candidate
// key it runs the three S-memory phases in order (init loop, key-schedule
// loop, decrypt/check loop), separating them with a one-cycle gap in which all
// phase enables are low so each sub-block returns to its own reset state. It
// owns the single shared S-RAM port and routes it to whichever phase is active.
// The key is stepped from KEY_MIN to KEY_MAX until the decrypt phase reports a
// valid plaintext, the range is exhausted, or a phase overstays PHASE_TIMEOUT.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   level; a registered rising edge launches a search
//   init/ksa/prga_start     level enables to the three phase blocks
//   init/ksa/prga_done      phase-finished indications
//   prga_ok                 plaintext valid, meaningful only with prga_done
//   init/ksa/prga_addr/data/wren  per-phase S-RAM requests
//   s_addr, s_data, s_wren  shared S-RAM port (combinational mux)
//   sec_key                 current candidate key
//   busy                    search in progress
//   found, fail, timeout    sticky result flags
// -----------------------------------------------------------------------------
module rc4_phase_sequencer #(
  parameter logic [23:0] KEY_MIN       = 24'h000000,
  parameter logic [23:0] KEY_MAX       = 24'h3FFFFF,
  parameter int unsigned PHASE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        init_start,
  input  logic        init_done,
  output logic        ksa_start,
  input  logic        ksa_done,
  output logic        prga_start,
  input  logic        prga_done,
  input  logic        prga_ok,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_data,
  input  logic        init_wren,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  ksa_data,
  input  logic        ksa_wren,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  prga_data,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_data,
  output logic        s_wren,
  output logic [23:0] sec_key,
  output logic        busy,
  output logic        found,
  output logic        fail,
  output logic        timeout
);

  // State encoding kept as plain constants for compatibility with older flows.
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_INIT  = 4'd1;
  localparam logic [3:0] ST_GAP1  = 4'd2;
  localparam logic [3:0] ST_KSA   = 4'd3;
  localparam logic [3:0] ST_GAP2  = 4'd4;
  localparam logic [3:0] ST_PRGA  = 4'd5;
  localparam logic [3:0] ST_CHECK = 4'd6;
  localparam logic [3:0] ST_FOUND = 4'd7;
  localparam logic [3:0] ST_FAIL  = 4'd8;

  // The counter only has to reach PHASE_TIMEOUT-1: the phase is abandoned on
  // the cycle it would count past that, so it never wraps.
  localparam int unsigned    CNT_W    = (PHASE_TIMEOUT > 1) ? $clog2(PHASE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_TIMEOUT - 1);

  logic [3:0]       state_q,     state_d;
  logic [23:0]      sec_key_q,   sec_key_d;
  logic             busy_q,      busy_d;
  logic             found_q,     found_d;
  logic             fail_q,      fail_d;
  logic             timeout_q,   timeout_d;
  logic             ok_q,        ok_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic             start_q;
  logic             start_prev_q;

  logic in_phase;
  logic phase_done;
  logic phase_expired;
  logic start_edge;

  // Two-stage start sampling: the edge is decided from registered samples so
  // an asynchronous, bouncing start level cannot reach the state logic.
  assign start_edge    = start_q & ~start_prev_q;
  assign in_phase      = (state_q == ST_INIT) || (state_q == ST_KSA) || (state_q == ST_PRGA);
  assign phase_expired = (phase_cnt_q == CNT_LAST);

  // Only the done of the phase currently running is listened to; stray dones
  // from idle blocks are dropped here.
  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      ST_INIT: phase_done = init_done;
      ST_KSA:  phase_done = ksa_done;
      ST_PRGA: phase_done = prga_done;
      default: phase_done = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no branch of
    // the case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    sec_key_d   = sec_key_q;
    busy_d      = busy_q;
    found_d     = found_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    ok_d        = ok_q;
    // Counter is held at zero outside the phases, so it is already cleared on
    // the first cycle of every phase.
    phase_cnt_d = in_phase ? (phase_cnt_q + CNT_W'(1)) : '0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_INIT;
          sec_key_d = KEY_MIN;
          busy_d    = 1'b1;
        end
      end

      ST_INIT, ST_KSA, ST_PRGA: begin
        // A done arriving on the limit cycle still counts as success.
        if (phase_done) begin
          case (state_q)
            ST_INIT: state_d = ST_GAP1;
            ST_KSA:  state_d = ST_GAP2;
            default: begin
              state_d = ST_CHECK;
              ok_d    = prga_ok;
            end
          endcase
        end else if (phase_expired) begin
          state_d   = ST_FAIL;
          busy_d    = 1'b0;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end

      ST_GAP1: state_d = ST_KSA;
      ST_GAP2: state_d = ST_PRGA;

      ST_CHECK: begin
        if (ok_q) begin
          state_d = ST_FOUND;
          busy_d  = 1'b0;
          found_d = 1'b1;
        end else if (sec_key_q == KEY_MAX) begin
          state_d = ST_FAIL;
          busy_d  = 1'b0;
          fail_d  = 1'b1;
        end else begin
          state_d   = ST_INIT;
          sec_key_d = sec_key_q + 24'd1;
        end
      end

      ST_FOUND, ST_FAIL: begin
        // Results stay visible until the host acknowledges with a new edge.
        if (start_edge) begin
          state_d   = ST_IDLE;
          found_d   = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sec_key_q    <= KEY_MIN;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      ok_q         <= 1'b0;
      phase_cnt_q  <= '0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      sec_key_q    <= sec_key_d;
      busy_q       <= busy_d;
      found_q      <= found_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      ok_q         <= ok_d;
      phase_cnt_q  <= phase_cnt_d;
      start_q      <= start;
      start_prev_q <= start_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Enables decode straight from the state register: glitch-free, high from
  // the first cycle of the phase, and low in the gaps and terminal states.
  assign init_start = (state_q == ST_INIT);
  assign ksa_start  = (state_q == ST_KSA);
  assign prga_start = (state_q == ST_PRGA);

  assign sec_key = sec_key_q;
  assign busy    = busy_q;
  assign found   = found_q;
  assign fail    = fail_q;
  assign timeout = timeout_q;

  // Shared S-RAM port: the registered state picks the owner, so a gap cycle
  // or terminal state forces the port quiet and no write can leak through.
  always_comb begin
    s_addr = 8'h00;
    s_data = 8'h00;
    s_wren = 1'b0;
    case (state_q)
      ST_INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      ST_KSA: begin
        s_addr = ksa_addr;
        s_data = ksa_data;
        s_wren = ksa_wren;
      end
      ST_PRGA: begin
        s_addr = prga_addr;
        s_data = prga_data;
        s_wren = prga_wren;
      end
      default: begin
        s_addr = 8'h00;
        s_data = 8'h00;
        s_wren = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rc4_phase_sequencer
//
// Stub phase blocks answer the sequencer's enables after per-pass lengths held
// in len_tab. The expected behaviour is a timeline: for each search the bench
// lays out, cycle by cycle, which phase owns the port and what the flags and
// key must be, derived only from the phase lengths and the key range. One
// compare process checks the DUT against that timeline every cycle.
// -----------------------------------------------------------------------------
module tb_rc4_phase_sequencer;

  localparam logic [23:0] KMIN  = 24'h000249;
  localparam logic [23:0] KMAX  = 24'h00024E;
  localparam int          NKEYS = 6;
  localparam int          T     = 24;
  localparam int          NEVER = 100000;
  localparam int          HOLD  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        init_start, ksa_start, prga_start;
  logic        init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0, prga_ok = 1'b0;
  logic [7:0]  init_addr = 8'h00, ksa_addr = 8'h00, prga_addr = 8'h00;
  logic [7:0]  init_data = 8'h00, ksa_data = 8'h00, prga_data = 8'h00;
  logic        init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
  logic [7:0]  s_addr, s_data;
  logic        s_wren;
  logic [23:0] sec_key;
  logic        busy, found, fail, timeout;

  always #5 clk = ~clk;

  rc4_phase_sequencer #(
    .KEY_MIN(KMIN), .KEY_MAX(KMAX), .PHASE_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .init_start(init_start), .init_done(init_done),
    .ksa_start(ksa_start), .ksa_done(ksa_done),
    .prga_start(prga_start), .prga_done(prga_done), .prga_ok(prga_ok),
    .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren),
    .sec_key(sec_key), .busy(busy), .found(found), .fail(fail), .timeout(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Stub phase blocks
  // ---------------------------------------------------------------------------
  int       len_tab [NKEYS][3];
  int       ok_idx   = -1;
  int       pass_idx = -1;
  int       cnt [3]  = '{0, 0, 0};
  logic [2:0] st_prev = 3'b000;
  logic [2:0] st_now;
  int       pi;
  bit       ovr = 1'b0;

  always begin
    @(posedge clk);
    #1;
    st_now = {prga_start, ksa_start, init_start};
    if (st_now[0] && !st_prev[0]) pass_idx++;
    st_prev = st_now;
    pi = (pass_idx < 0 || pass_idx >= NKEYS) ? 0 : pass_idx;
    for (int p = 0; p < 3; p++) cnt[p] = st_now[p] ? cnt[p] + 1 : 0;
    // Idle blocks emit random dones, which the sequencer must ignore.
    init_done = st_now[0] ? (cnt[0] == len_tab[pi][0]) : ($urandom_range(3) == 0);
    ksa_done  = st_now[1] ? (cnt[1] == len_tab[pi][1]) : ($urandom_range(3) == 0);
    prga_done = st_now[2] ? (cnt[2] == len_tab[pi][2]) : ($urandom_range(3) == 0);
    prga_ok   = (st_now[2] && prga_done) ? (pass_idx == ok_idx) : 1'($urandom_range(1));
    if (!ovr) begin
      init_addr = 8'($urandom); init_data = 8'($urandom); init_wren = 1'($urandom_range(1));
      ksa_addr  = 8'($urandom); ksa_data  = 8'($urandom); ksa_wren  = 1'($urandom_range(1));
      prga_addr = 8'($urandom); prga_data = 8'($urandom); prga_wren = 1'($urandom_range(1));
    end
  end

  // ---------------------------------------------------------------------------
  // Timeline model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]  ph;     // 0 none, 1 init, 2 ksa, 3 prga owns the port
    logic        busy;
    logic        found;
    logic        fail;
    logic        tmo;
    logic [23:0] key;
  } exp_t;

  exp_t        exp_tab [int];
  exp_t        last_term;
  logic [23:0] m_key = KMIN;
  int          drop_at = -1;

  function automatic exp_t mk(input logic [1:0] ph, input logic b, input logic f,
                              input logic fl, input logic t, input logic [23:0] k);
    exp_t e;
    e.ph = ph; e.busy = b; e.found = f; e.fail = fl; e.tmo = t; e.key = k;
    return e;
  endfunction

  task automatic fill(input int from, input int upto, input exp_t e);
    for (int c = from; c < upto; c++) exp_tab[c] = e;
  endtask

  // Lay out the search starting with the first INIT cycle at c0; returns the
  // first cycle of the terminal state.
  task automatic build(input int c0, output int c_term);
    int c, l, n;
    logic [23:0] key;
    c = c0;
    c_term = c0;
    for (int k = 0; k < NKEYS; k++) begin
      key = KMIN + 24'(k);
      for (int p = 0; p < 3; p++) begin
        l = len_tab[k][p];
        n = (l > T) ? T : l;
        for (int j = 0; j < n; j++) begin
          exp_tab[c] = mk(2'(p + 1), 1'b1, 1'b0, 1'b0, 1'b0, key);
          c++;
        end
        if (l > T) begin
          last_term = mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, key);
          m_key = key;
          c_term = c;
          return;
        end
        exp_tab[c] = mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, key);  // gap or check cycle
        c++;
      end
      if (k == ok_idx) begin
        last_term = mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, key);
        m_key = key;
        c_term = c;
        return;
      end
    end
    last_term = mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, KMAX);
    m_key = KMAX;
    c_term = c;
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the timeline
  // ---------------------------------------------------------------------------
  exp_t        ce;
  logic [16:0] bus_exp;

  always @(negedge clk) begin
    if (reset_n && exp_tab.exists(cyc)) begin
      ce = exp_tab[cyc];
      case (ce.ph)
        2'd1:    bus_exp = {init_addr, init_data, init_wren};
        2'd2:    bus_exp = {ksa_addr, ksa_data, ksa_wren};
        2'd3:    bus_exp = {prga_addr, prga_data, prga_wren};
        default: bus_exp = 17'h0;
      endcase
      check("starts", {61'h0, init_start, ksa_start, prga_start},
            {61'h0, ce.ph == 2'd1, ce.ph == 2'd2, ce.ph == 2'd3});
      check("flags", {60'h0, busy, found, fail, timeout},
            {60'h0, ce.busy, ce.found, ce.fail, ce.tmo});
      check("sec_key", {40'h0, sec_key}, {40'h0, ce.key});
      check("s_bus", {47'h0, s_addr, s_data, s_wren}, {47'h0, bus_exp});
      exp_tab.delete(cyc);
    end
  end

  // Rise monitor for the directed latency checks.
  int         init_rise = 0, ksa_rise = 0, found_rise = 0, fail_rise = 0, init_rises = 0;
  logic [3:0] mon_prev = 4'b0000;

  always @(negedge clk) begin
    if (init_start && !mon_prev[0]) begin init_rise = cyc; init_rises++; end
    if (ksa_start && !mon_prev[1]) ksa_rise = cyc;
    if (found && !mon_prev[2]) found_rise = cyc;
    if (fail && !mon_prev[3]) fail_rise = cyc;
    mon_prev = {fail, found, ksa_start, init_start};
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called aligned to posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      if (cyc == drop_at) start = 1'b0;
    end
  endtask

  task automatic set_lens_fixed(input int li, input int lk, input int lp);
    for (int k = 0; k < NKEYS; k++) begin
      len_tab[k][0] = li; len_tab[k][1] = lk; len_tab[k][2] = lp;
    end
  endtask

  task automatic set_lens_rand(input int mode);
    int kt, pt;
    for (int k = 0; k < NKEYS; k++)
      for (int p = 0; p < 3; p++)
        len_tab[k][p] = ($urandom_range(7) == 0) ? T : int'($urandom_range(20, 1));
    case (mode)
      0: ok_idx = int'($urandom_range(NKEYS - 1));
      1: ok_idx = -1;
      default: begin
        ok_idx = int'($urandom_range(NKEYS)) - 1;
        kt = int'($urandom_range(NKEYS - 1));
        pt = int'($urandom_range(2));
        len_tab[kt][pt] = T + 1 + int'($urandom_range(5));
      end
    endcase
  endtask

  task automatic launch(input bit allow_drop, output int n, output int ct);
    n = cyc;
    pass_idx = -1;
    exp_tab[n + 1] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, m_key);
    start = 1'b1;
    build(n + 2, ct);
    fill(ct, ct + HOLD + 5, last_term);
    drop_at = (allow_drop && $urandom_range(1) == 1) ? int'($urandom_range(ct, n + 3)) : -1;
  endtask

  // Called at cycle c1 while in the terminal state: acknowledge back to IDLE
  // and leave start low long enough for the next launch.
  task automatic finish_search(input int c1);
    drop_at = -1;
    start = 1'b0;
    wait_cyc(c1 + 3);
    start = 1'b1;
    fill(c1 + 5, c1 + 9, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, m_key));
    wait_cyc(c1 + 5);
    start = 1'b0;
    wait_cyc(c1 + 8);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int n, ct;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_starts", {61'h0, init_start, ksa_start, prga_start}, 64'h0);
    check("rst_flags", {60'h0, busy, found, fail, timeout}, 64'h0);
    check("rst_key", {40'h0, sec_key}, 64'h249);
    check("rst_swren", {63'h0, s_wren}, 64'h0);
    reset_n = 1'b1;
    m_key = KMIN;
    fill(cyc, cyc + 4, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, KMIN));
    wait_cyc(cyc + 3);

    // Single pass, success on the first key, with mux isolation in KSA.
    set_lens_fixed(3, 4, 5);
    ok_idx = 0;
    launch(1'b0, n, ct);
    check("model_len", 64'(ct - (n + 2)), 64'd15);
    wait_cyc(n + 7);
    #1;
    ovr = 1'b1;
    init_wren = 1'b1; prga_wren = 1'b1; ksa_wren = 1'b0;
    #1;
    check("mux_ksa_idle", {63'h0, s_wren}, 64'h0);
    ksa_addr = 8'h7F; ksa_data = 8'hA5; ksa_wren = 1'b1;
    #1;
    check("mux_ksa_write", {47'h0, s_addr, s_data, s_wren}, {47'h0, 8'h7F, 8'hA5, 1'b1});
    wait_cyc(n + 8);
    ovr = 1'b0;
    wait_cyc(ct + HOLD);
    check("lat_init", 64'(init_rise - n), 64'd2);
    check("pass_len", 64'(found_rise - init_rise), 64'd15);
    check("d1_flags", {60'h0, busy, found, fail, timeout}, 64'b0100);
    check("d1_key", {40'h0, sec_key}, 64'h249);
    finish_search(ct + HOLD);

    // Search succeeds on the fourth key.
    set_lens_rand(0);
    ok_idx = 3;
    init_rises = 0;
    launch(1'b1, n, ct);
    wait_cyc(ct + HOLD);
    check("d2_passes", 64'(init_rises), 64'd4);
    check("d2_key", {40'h0, sec_key}, 64'h24C);
    check("d2_flags", {60'h0, busy, found, fail, timeout}, 64'b0100);
    finish_search(ct + HOLD);

    // Range exhausted.
    set_lens_rand(1);
    launch(1'b1, n, ct);
    wait_cyc(ct + HOLD);
    check("d3_flags", {60'h0, busy, found, fail, timeout}, 64'b0010);
    check("d3_key", {40'h0, sec_key}, 64'h24E);
    check("d3_swren", {63'h0, s_wren}, 64'h0);
    finish_search(ct + HOLD);

    // KSA never finishes.
    set_lens_fixed(2, NEVER, 1);
    ok_idx = -1;
    launch(1'b0, n, ct);
    wait_cyc(ct + HOLD);
    check("d4_tmo_len", 64'(fail_rise - ksa_rise), 64'(T));
    check("d4_flags", {60'h0, busy, found, fail, timeout}, 64'b0011);
    check("d4_ksa_start", {63'h0, ksa_start}, 64'h0);
    check("d4_key", {40'h0, sec_key}, 64'h249);
    finish_search(ct + HOLD);

    // Randomised searches: success, exhaustion, timeout.
    for (int i = 0; i < 24; i++) begin
      set_lens_rand(i % 3);
      launch(1'b1, n, ct);
      wait_cyc(ct + HOLD);
      finish_search(ct + HOLD);
    end

    // Asynchronous reset in the second key's PRGA, then a clean restart.
    set_lens_fixed(2, 2, 15);
    ok_idx = -1;
    launch(1'b0, n, ct);
    wait_cyc(n + 35);
    check("pre_rst_prga", {63'h0, prga_start}, 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_starts", {61'h0, init_start, ksa_start, prga_start}, 64'h0);
    check("rst_mid_swren", {63'h0, s_wren}, 64'h0);
    check("rst_mid_busy", {63'h0, busy}, 64'h0);
    check("rst_mid_key", {40'h0, sec_key}, 64'h249);
    exp_tab.delete();
    start = 1'b0;
    drop_at = -1;
    m_key = KMIN;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    fill(cyc, cyc + 4, mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, KMIN));
    wait_cyc(cyc + 3);
    set_lens_fixed(2, 3, 4);
    ok_idx = 1;
    launch(1'b0, n, ct);
    wait_cyc(ct + HOLD);
    check("post_rst_key", {40'h0, sec_key}, 64'h24A);
    check("post_rst_flags", {60'h0, busy, found, fail, timeout}, 64'b0100);
    finish_search(ct + HOLD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
